// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared hour-digit widths, wrap constants and binary-to-BCD helper
package clock_pkg;

  localparam int HH_TENS_W     = 2;
  localparam int HH_UNITS_W    = 4;
  localparam int HH_WRAP_TENS  = 2;
  localparam int HH_WRAP_UNITS = 3;

  // Converts a binary hour 0..23 into {tens, units} BCD, used for reset constants.
  function automatic logic [HH_TENS_W+HH_UNITS_W-1:0] hh_to_bcd(input int hh);
    int t;
    int u;
    t = hh / 10;
    u = hh % 10;
    return {t[HH_TENS_W-1:0], u[HH_UNITS_W-1:0]};
  endfunction

endpackage

// File: rtl/hh24_counter_bcd_mod24.sv
// rtl/hh24_counter_bcd_mod24.sv - one mod-24 BCD hour register with increment and wrap pulse
module bcd_mod24
  import clock_pkg::*;
(
  input  logic                  i_ck,
  input  logic                  i_reset,
  input  logic [HH_TENS_W-1:0]  i_init_tens,
  input  logic [HH_UNITS_W-1:0] i_init_units,
  input  logic                  i_up,
  output logic [HH_TENS_W-1:0]  o_tens,
  output logic [HH_UNITS_W-1:0] o_units,
  output logic [HH_TENS_W-1:0]  o_next_tens,
  output logic [HH_UNITS_W-1:0] o_next_units,
  output logic                  o_wrap
);

  logic [HH_TENS_W-1:0]  r_tens;
  logic [HH_UNITS_W-1:0] r_units;
  logic                  w_at_wrap;
  logic                  w_illegal;

  assign w_at_wrap = (r_tens == HH_TENS_W'(HH_WRAP_TENS)) && (r_units == HH_UNITS_W'(HH_WRAP_UNITS));
  assign w_illegal = (r_units > 4'd9) || (r_tens == 2'd3) ||
                     ((r_tens == HH_TENS_W'(HH_WRAP_TENS)) && (r_units > HH_UNITS_W'(HH_WRAP_UNITS)));

  // Next state includes reset so the top can register hh_match from it directly.
  always_comb begin
    o_next_tens  = r_tens;
    o_next_units = r_units;
    o_wrap       = 1'b0;
    if (!i_reset) begin
      o_next_tens  = i_init_tens;
      o_next_units = i_init_units;
    end else if (i_up) begin
      if (w_illegal) begin
        o_next_tens  = '0;
        o_next_units = '0;
      end else if (w_at_wrap) begin
        o_next_tens  = '0;
        o_next_units = '0;
        o_wrap       = 1'b1;
      end else if (r_units == 4'd9) begin
        o_next_tens  = r_tens + 2'd1;
        o_next_units = '0;
      end else begin
        o_next_units = r_units + 4'd1;
      end
    end
  end

  always_ff @(posedge i_ck) begin
    r_tens  <= o_next_tens;
    r_units <= o_next_units;
  end

  assign o_tens  = r_tens;
  assign o_units = r_units;

endmodule

// File: rtl/hh24_counter.sv
// rtl/hh24_counter.sv - clock/alarm hour registers, carry, match and display mux (HH24_12H_DISPLAY_EN)
module hh24_counter
  import clock_pkg::*;
#(
  parameter int CLK_RESET_HH = 0,
  parameter int ALM_RESET_HH = 7
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic                  up_clock24,
  input  logic                  up_alarm24,
  input  logic                  clock_alarm,
  output logic [HH_TENS_W-1:0]  clk_hh_tens,
  output logic [HH_UNITS_W-1:0] clk_hh_units,
  output logic [HH_TENS_W-1:0]  alm_hh_tens,
  output logic [HH_UNITS_W-1:0] alm_hh_units,
  output logic [HH_TENS_W-1:0]  disp_tens,
  output logic [HH_UNITS_W-1:0] disp_units,
  output logic                  carry_24,
  output logic                  hh_match,
  output logic                  pm
);

  localparam logic [HH_TENS_W+HH_UNITS_W-1:0] CLK_INIT = hh_to_bcd(CLK_RESET_HH);
  localparam logic [HH_TENS_W+HH_UNITS_W-1:0] ALM_INIT = hh_to_bcd(ALM_RESET_HH);

  logic [HH_TENS_W-1:0]  w_clk_next_tens, w_alm_next_tens, w_sel_tens;
  logic [HH_UNITS_W-1:0] w_clk_next_units, w_alm_next_units, w_sel_units;
  logic                  w_clk_wrap, w_alm_wrap_unused;
  logic                  r_carry, r_match;

  bcd_mod24 u_clk (
    .i_ck         (ck),
    .i_reset      (reset),
    .i_init_tens  (CLK_INIT[HH_TENS_W+HH_UNITS_W-1:HH_UNITS_W]),
    .i_init_units (CLK_INIT[HH_UNITS_W-1:0]),
    .i_up         (up_clock24),
    .o_tens       (clk_hh_tens),
    .o_units      (clk_hh_units),
    .o_next_tens  (w_clk_next_tens),
    .o_next_units (w_clk_next_units),
    .o_wrap       (w_clk_wrap)
  );

  bcd_mod24 u_alm (
    .i_ck         (ck),
    .i_reset      (reset),
    .i_init_tens  (ALM_INIT[HH_TENS_W+HH_UNITS_W-1:HH_UNITS_W]),
    .i_init_units (ALM_INIT[HH_UNITS_W-1:0]),
    .i_up         (up_alarm24),
    .o_tens       (alm_hh_tens),
    .o_units      (alm_hh_units),
    .o_next_tens  (w_alm_next_tens),
    .o_next_units (w_alm_next_units),
    .o_wrap       (w_alm_wrap_unused)
  );

  always_ff @(posedge ck) begin
    r_carry <= w_clk_wrap;
    r_match <= (w_clk_next_tens == w_alm_next_tens) && (w_clk_next_units == w_alm_next_units);
  end

  assign carry_24 = r_carry;
  assign hh_match = r_match;

  assign w_sel_tens  = clock_alarm ? clk_hh_tens  : alm_hh_tens;
  assign w_sel_units = clock_alarm ? clk_hh_units : alm_hh_units;

`ifdef HH24_12H_DISPLAY_EN
  logic [4:0] w_sel_bin, w_h12;
  logic       w_h12_ge10;

  assign w_sel_bin  = 5'(w_sel_tens) * 5'd10 + 5'(w_sel_units);
  assign w_h12      = (w_sel_bin == 5'd0) ? 5'd12 :
                      (w_sel_bin > 5'd12) ? (w_sel_bin - 5'd12) : w_sel_bin;
  assign w_h12_ge10 = (w_h12 >= 5'd10);
  assign disp_tens  = w_h12_ge10 ? 2'd1 : 2'd0;
  assign disp_units = 4'(w_h12 - (w_h12_ge10 ? 5'd10 : 5'd0));
  assign pm         = (w_sel_bin >= 5'd12);
`else
  assign disp_tens  = w_sel_tens;
  assign disp_units = w_sel_units;
  assign pm         = 1'b0;
`endif

endmodule
